// File: rtl/radio_lane_arb.sv
// radio_lane_arb: round-robin merge of NLANE paired I/Q byte streams into one 16-bit AXI-Stream
// Ports:
//   clk_250m, reset          block clock, asynchronous active-high reset
//   lane_en                  per-lane arbitration enable, looked at only while idle
//   s_axis_I_* / s_axis_Q_*  per-lane 8-bit I and Q streams, consumed together as one beat
//   m_axis_*                 merged stream: tdata = {Q,I}, tuser = source lane, tlast = end of packet
//   err_tlast_mismatch       sticky: I and Q tlast disagreed on an accepted beat
//   err_overlen              sticky: a packet was cut at MAX_BEATS
//   err_clr                  synchronous clear of both sticky flags; a same-cycle set wins
module radio_lane_arb #(
    parameter int NLANE = 8,
    parameter int MAX_BEATS = 4096,
    localparam int LW = NLANE > 1 ? $clog2(NLANE) : 1,
    localparam int CW = $clog2(MAX_BEATS + 1)
) (
    input  logic                  clk_250m,
    input  logic                  reset,
    input  logic [NLANE-1:0]      lane_en,
    input  logic [NLANE-1:0]      s_axis_I_tvalid,
    output logic [NLANE-1:0]      s_axis_I_tready,
    input  logic [NLANE-1:0][7:0] s_axis_I_tdata,
    input  logic [NLANE-1:0]      s_axis_I_tlast,
    input  logic [NLANE-1:0]      s_axis_Q_tvalid,
    output logic [NLANE-1:0]      s_axis_Q_tready,
    input  logic [NLANE-1:0][7:0] s_axis_Q_tdata,
    input  logic [NLANE-1:0]      s_axis_Q_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [15:0]           m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [LW-1:0]         m_axis_tuser,
    output logic                  err_tlast_mismatch,
    output logic                  err_overlen,
    input  logic                  err_clr
);
    typedef enum logic {IDLE, BUSY} stateT;

    stateT state, stateNext;
    logic [LW-1:0] grant, grantNext, rrPtr, rrPtrNext, pick, cand;
    logic [CW-1:0] beatCnt;
    logic [NLANE-1:0] req;
    logic outFree, accept, lastBeat, iLast, qLast, atMax;

    assign req = lane_en & s_axis_I_tvalid & s_axis_Q_tvalid;
    assign outFree = !m_axis_tvalid || m_axis_tready;
    assign iLast = s_axis_I_tlast[grant];
    assign qLast = s_axis_Q_tlast[grant];
    assign atMax = beatCnt == CW'(MAX_BEATS - 1);
    assign lastBeat = iLast || qLast || atMax;

    // Scan offsets from the far end back towards rrPtr so the nearest requester wins.
    always_comb begin
        pick = rrPtr;
        cand = rrPtr;
        for (int k = NLANE - 1; k >= 0; k--) begin
            cand = int'(rrPtr) + k >= NLANE ? LW'(int'(rrPtr) + k - NLANE) : LW'(int'(rrPtr) + k);
            if (req[cand]) pick = cand;
        end
    end

    always_comb begin
        stateNext = state;
        grantNext = grant;
        rrPtrNext = rrPtr;
        s_axis_I_tready = '0;
        s_axis_Q_tready = '0;
        accept = 1'b0;
        if (state == IDLE) begin
            stateNext = |req ? BUSY : IDLE;
            grantNext = |req ? pick : grant;
        end else begin
            // I and Q share one ready so the two halves of a beat always move together.
            s_axis_I_tready[grant] = outFree;
            s_axis_Q_tready[grant] = outFree;
            accept = s_axis_I_tvalid[grant] && s_axis_Q_tvalid[grant] && outFree;
            if (accept && lastBeat) begin
                stateNext = IDLE;
                rrPtrNext = grant == LW'(NLANE - 1) ? '0 : grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_250m or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            rrPtr <= '0;
        end else begin
            state <= stateNext;
            grant <= grantNext;
            rrPtr <= rrPtrNext;
        end
    end

    always_ff @(posedge clk_250m or posedge reset) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tlast <= 1'b0;
            m_axis_tuser <= '0;
            beatCnt <= '0;
            err_tlast_mismatch <= 1'b0;
            err_overlen <= 1'b0;
        end else begin
            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata <= {s_axis_Q_tdata[grant], s_axis_I_tdata[grant]};
                m_axis_tlast <= lastBeat;
                m_axis_tuser <= grant;
                beatCnt <= lastBeat ? '0 : beatCnt + 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            err_tlast_mismatch <= (accept && iLast != qLast) || (err_tlast_mismatch && !err_clr);
            err_overlen <= (accept && atMax && !iLast && !qLast) || (err_overlen && !err_clr);
        end
    end
endmodule

// File: tb/tb_radio_lane_arb.sv
// tb_radio_lane_arb: randomized and directed checks of radio_lane_arb against a per-lane scoreboard
module tb_radio_lane_arb;
    localparam int NL = 8;
    localparam int MAXB = 4;

    typedef struct packed {
        logic [7:0] i;
        logic [7:0] q;
        logic il;
        logic ql;
    } beatT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NL-1:0] laneEn, iValid, iReady, iLast, qValid, qReady, qLast;
    logic [NL-1:0][7:0] iData, qData;
    logic mValid, mReady, mLast, errMis, errOver, errClr;
    logic [15:0] mData;
    logic [2:0] mUser;

    always #2 clk = ~clk;

    radio_lane_arb #(.NLANE(NL), .MAX_BEATS(MAXB)) dut (
        .clk_250m(clk),
        .reset(rst),
        .lane_en(laneEn),
        .s_axis_I_tvalid(iValid),
        .s_axis_I_tready(iReady),
        .s_axis_I_tdata(iData),
        .s_axis_I_tlast(iLast),
        .s_axis_Q_tvalid(qValid),
        .s_axis_Q_tready(qReady),
        .s_axis_Q_tdata(qData),
        .s_axis_Q_tlast(qLast),
        .m_axis_tvalid(mValid),
        .m_axis_tready(mReady),
        .m_axis_tdata(mData),
        .m_axis_tlast(mLast),
        .m_axis_tuser(mUser),
        .err_tlast_mismatch(errMis),
        .err_overlen(errOver),
        .err_clr(errClr)
    );

    int tests = 0, fails = 0, cyc = 0;
    beatT srcQ[NL][$];
    beatT expQ[NL][$];
    int order[$];
    logic [NL-1:0] presenting, hs;
    bit dense, expMis, expOver, clrOnOut;
    int readyMode, holdLow, curLane, pos, outCount, firstOutCyc, startCyc;
    logic pValid, pReady, pLast;
    logic [15:0] pData;
    logic [2:0] pUser;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic beatT mk(logic [7:0] i, logic [7:0] q, logic il, logic ql);
        beatT b;
        b.i = i;
        b.q = q;
        b.il = il;
        b.ql = ql;
        return b;
    endfunction

    function automatic bit allEmpty();
        for (int l = 0; l < NL; l++)
            if (srcQ[l].size() != 0 || expQ[l].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        for (int l = 0; l < NL; l++) begin
            if (!presenting[l] && srcQ[l].size() > 0 && (dense || $urandom_range(3) != 0)) presenting[l] = 1'b1;
            iValid[l] = presenting[l];
            qValid[l] = presenting[l];
            iData[l] = presenting[l] ? srcQ[l][0].i : 8'($urandom);
            qData[l] = presenting[l] ? srcQ[l][0].q : 8'($urandom);
            iLast[l] = presenting[l] ? srcQ[l][0].il : 1'b0;
            qLast[l] = presenting[l] ? srcQ[l][0].ql : 1'b0;
        end
        mReady = readyMode == 0 ? 1'b1 : 1'($urandom_range(1));
        if (holdLow > 0) begin
            mReady = 1'b0;
            holdLow--;
        end
    endtask

    task automatic scoreBeat();
        beatT b;
        int u;
        bit lastExp;
        u = int'(mUser);
        outCount++;
        if (firstOutCyc < 0) firstOutCyc = cyc;
        if (curLane < 0) begin
            order.push_back(u);
            curLane = u;
        end else begin
            check("noInterleave", 32'(mUser), curLane);
        end
        if (expQ[u].size() == 0) begin
            check("beatKnown", 0, 1);
            return;
        end
        b = expQ[u].pop_front();
        lastExp = b.il || b.ql || pos == MAXB - 1;
        if (b.il != b.ql) expMis = 1'b1;
        if (pos == MAXB - 1 && !b.il && !b.ql) expOver = 1'b1;
        check("data", mData, {b.q, b.i});
        check("last", mLast, lastExp);
        check("errMis", errMis, expMis);
        check("errOver", errOver, expOver);
        pos = lastExp ? 0 : pos + 1;
        if (lastExp) curLane = -1;
        if (clrOnOut) begin
            errClr = 1'b0;
            clrOnOut = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("readyPair", iReady, qReady);
        check("readyOneHot", 32'($countones(iReady) <= 1), 1);
        if (mValid && !mReady) check("readyHeldOff", iReady, 0);
        if (pValid && !pReady) check("holdStable", {mValid, mLast, mUser, mData}, {1'b1, pLast, pUser, pData});
        if (mValid && mReady) scoreBeat();
        {pValid, pReady, pLast, pUser, pData} = {mValid, mReady, mLast, mUser, mData};
        hs = iValid & iReady & qValid & qReady;
        @(posedge clk);
        cyc++;
        if (errClr) begin
            expMis = 1'b0;
            expOver = 1'b0;
        end
        for (int l = 0; l < NL; l++)
            if (hs[l]) begin
                expQ[l].push_back(srcQ[l].pop_front());
                presenting[l] = 1'b0;
            end
        #1 drive();
    endtask

    task automatic applyReset();
        rst = 1'b1;
        #1;
        check("rstOut", {mValid, mLast, mUser, mData}, 0);
        check("rstReady", {iReady, qReady}, 0);
        check("rstErr", {errMis, errOver}, 0);
        for (int l = 0; l < NL; l++) begin
            srcQ[l].delete();
            expQ[l].delete();
        end
        presenting = '0;
        hs = '0;
        pValid = 1'b0;
        curLane = -1;
        pos = 0;
        expMis = 1'b0;
        expOver = 1'b0;
        drive();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic runDrain(string tag, int maxCyc);
        int n;
        n = 0;
        while (!allEmpty() && n < maxCyc) begin
            step();
            n++;
        end
        check({tag, "Drained"}, 32'(n < maxCyc), 1);
    endtask

    task automatic waitOut(int k);
        int n;
        n = 0;
        while (outCount < k && n < 100) begin
            step();
            n++;
        end
        check("waitOut", 32'(outCount >= k), 1);
    endtask

    task automatic pushPkt(int l, int len, logic [7:0] base);
        for (int k = 0; k < len; k++)
            srcQ[l].push_back(mk(base + 8'(k), base + 8'(k) + 8'h10, k == len - 1, k == len - 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        laneEn = '1;
        errClr = 1'b0;
        readyMode = 0;
        holdLow = 0;
        dense = 1'b1;
        clrOnOut = 1'b0;
        presenting = '0;
        applyReset();

        // single lane 3, four beats, latency and tuser
        outCount = 0;
        firstOutCyc = -1;
        order.delete();
        pushPkt(3, 4, 8'h10);
        step();
        startCyc = cyc;
        runDrain("single", 50);
        check("latency", 32'(firstOutCyc - startCyc), 2);
        check("singleCount", outCount, 4);
        check("singleLane", order.size() > 0 ? order[0] : -1, 3);

        // all lanes with two 2-beat packets each: grant order must rotate
        applyReset();
        order.delete();
        for (int r = 0; r < 2; r++)
            for (int l = 0; l < NL; l++) pushPkt(l, 2, 8'(16 * l + 4 * r));
        runDrain("rotate", 300);
        check("rotateCount", order.size(), 2 * NL);
        for (int j = 0; j < order.size(); j++) check("rotateOrder", order[j], j % NL);

        // backpressure mid-packet
        applyReset();
        outCount = 0;
        pushPkt(1, 3, 8'h40);
        waitOut(2);
        holdLow = 5;
        runDrain("backpressure", 60);
        check("bpCount", outCount, 3);

        // over-length packet on lane 5
        applyReset();
        order.delete();
        pushPkt(5, 6, 8'h60);
        srcQ[5][3].il = 1'b0;
        runDrain("overlen", 60);
        check("overSet", errOver, 1);
        check("overPkts", order.size(), 2);

        // tlast mismatch on lane 2, clear, then clear colliding with a new mismatch
        srcQ[2].push_back(mk(8'h70, 8'h80, 1'b0, 1'b0));
        srcQ[2].push_back(mk(8'h71, 8'h81, 1'b1, 1'b0));
        runDrain("mismatch", 60);
        check("misSet", errMis, 1);
        errClr = 1'b1;
        step();
        errClr = 1'b0;
        check("misClr", errMis, 0);
        check("overClr", errOver, 0);
        errClr = 1'b1;
        clrOnOut = 1'b1;
        srcQ[2].push_back(mk(8'h72, 8'h82, 1'b1, 1'b0));
        runDrain("setWins", 60);
        errClr = 1'b0;
        check("setWins", errMis, 1);

        // reset in the middle of a lane 6 packet, then lane 0 must win
        outCount = 0;
        pushPkt(6, 3, 8'h90);
        waitOut(1);
        applyReset();
        order.delete();
        pushPkt(7, 1, 8'hA0);
        pushPkt(6, 1, 8'hB0);
        pushPkt(0, 1, 8'hC0);
        runDrain("afterReset", 60);
        check("afterResetFirst", order.size() > 0 ? order[0] : -1, 0);
        check("afterResetCount", order.size(), 3);

        // lane_en dropped mid-packet does not abort it
        applyReset();
        laneEn = 8'h40;
        outCount = 0;
        pushPkt(6, 3, 8'hD0);
        waitOut(1);
        laneEn = '0;
        runDrain("laneEnDrop", 60);
        check("laneEnCount", outCount, 3);
        laneEn = '1;

        // randomized traffic
        applyReset();
        readyMode = 1;
        dense = 1'b0;
        for (int p = 0; p < 150; p++) begin
            int l, len, mk0;
            l = $urandom_range(NL - 1);
            len = $urandom_range(1, 7);
            mk0 = $urandom_range(9) == 0 ? $urandom_range(len - 1) : -1;
            for (int k = 0; k < len; k++) begin
                beatT b;
                b = mk(8'($urandom), 8'($urandom), k == len - 1, k == len - 1);
                if (k == mk0) b.il = !b.il;
                srcQ[l].push_back(b);
            end
        end
        begin
            int n;
            n = 0;
            while (!allEmpty() && n < 20000) begin
                if (n < 2000 && $urandom_range(15) == 0) laneEn = NL'($urandom);
                else if (n >= 2000) laneEn = '1;
                step();
                n++;
            end
            check("randDrained", 32'(n < 20000), 1);
        end
        repeat (3) step();
        check("randErrMis", errMis, expMis);
        check("randErrOver", errOver, expOver);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/radio_lane_arb.md
Name: radio_lane_arb

Overview:
- Round-robin packet arbiter that merges the 8 per-lane I/Q byte streams from the receive chain into one 16-bit AXI-Stream toward the DMA path.
- Each lane's I and Q beats are consumed together, packed as {Q,I}, and tagged with the lane index.
- A grant is held for a whole packet, until tlast, so packets from different lanes never interleave.
- Also polices over-length packets and I/Q tlast mismatches.

Parameters:
- NLANE, 8, number of lanes; the lane-index width is clog2(NLANE).
- MAX_BEATS, 4096, maximum beats per packet before the arbiter forces tlast.

Ports:
- clk_250m  in  1  block clock
- reset  in  1  asynchronous, active-high reset
- lane_en  in  NLANE  per-lane arbitration enable
- s_axis_I_tvalid[NLANE]  in  1  per-lane I valid
- s_axis_I_tready[NLANE]  out  1  per-lane I ready
- s_axis_I_tdata[NLANE]  in  8  per-lane I sample
- s_axis_I_tlast[NLANE]  in  1  per-lane I last
- s_axis_Q_tvalid / tready / tdata / tlast [NLANE]  in / out / in / in  1 / 1 / 8 / 1  per-lane Q stream, same roles as the I stream
- m_axis_tvalid  out  1  merged valid
- m_axis_tready  in  1  merged ready
- m_axis_tdata  out  16  {Q[7:0], I[7:0]}
- m_axis_tlast  out  1  end of packet
- m_axis_tuser  out  clog2(NLANE)  source lane index
- err_tlast_mismatch  out  1  sticky: I tlast differed from Q tlast on an accepted beat
- err_overlen  out  1  sticky: a packet was truncated at MAX_BEATS
- err_clr  in  1  synchronous clear of both sticky error flags

Behaviour:
- Reset (async, active high) values:
  - all m_axis_* = 0; all s_axis_*_tready = 0.
  - state = IDLE, rr_ptr = 0, beat_cnt = 0, both error flags = 0.
  - Reset mid-packet abandons the packet; no tlast is emitted for it.
- Lane request: req[i] = lane_en[i] & I_tvalid[i] & Q_tvalid[i].
- IDLE state:
  - If any req bit is set, grant the first requesting lane searching upward from rr_ptr, with wrap-around.
  - Register grant, go to BUSY. The arbitration decision costs 1 cycle.
  - No tready is asserted while in IDLE.
- BUSY state:
  - Define out_free = !m_axis_tvalid | m_axis_tready.
  - I_tready[g] = Q_tready[g] = out_free. The tready of every other lane is 0.
  - A beat is accepted when I_tvalid[g] & Q_tvalid[g] & out_free, and only then. A lone I or Q valid is never consumed. The two tready signals are identical, so the I and Q beats move together.
  - On an accepted beat, the output register loads:
    - tdata = {Q,I}, tuser = g, m_axis_tvalid = 1;
    - tlast = I_tlast | Q_tlast | (beat_cnt == MAX_BEATS-1).
  - Latency from input to output is 1 cycle.
  - If out_free holds and no beat is accepted, m_axis_tvalid clears.
  - Output data, tlast and tuser stay stable while m_axis_tvalid=1 and m_axis_tready=0.
- beat_cnt:
  - Increments on each accepted beat.
  - Clears when a beat is accepted with the loaded tlast = 1.
- Packet end: when an accepted beat loads tlast = 1:
  - go to IDLE next cycle; set rr_ptr = g+1 (mod NLANE).
  - Arbitration can overlap the drain of the last beat. Best case is one idle input cycle between packets.
- Forced tlast at MAX_BEATS without input tlast: set err_overlen. Later beats from that lane are treated as a new packet and must arbitrate again.
- Tlast mismatch: an accepted beat with I_tlast != Q_tlast sets err_tlast_mismatch. Output tlast is the OR of the two, and the packet ends.
- lane_en:
  - Sampled only in IDLE.
  - Deasserting it for the granted lane mid-packet does not abort that packet.
- Grant hold: in BUSY, the grant holds even while the granted lane's valids are low. There is no timeout.
- err_clr is synchronous.
  - If err_clr coincides with a new error event, the set wins.

Test Plan:
- Single lane 3 with lane_en=0xFF sends 4 beats, I=0x10..0x13, Q=0x20..0x23, tlast on beat 4, m_tready=1. Expect:
  - outputs 0x2010, 0x2111, 0x2212, 0x2313;
  - tuser=3 on every beat; tlast only on the 4th;
  - first output 2 cycles after valid (1 arbitration + 1 register).
- All 8 lanes continuously offer 2-beat packets. Expect:
  - grant order 0,1,2,…,7,0;
  - no interleaving within a packet;
  - rr_ptr advances to last grant + 1.
- Backpressure: m_tready low for 5 cycles mid-packet. Expect:
  - m_tdata, m_tlast and tuser held stable;
  - s tready for lane g = 0 while the output register is full;
  - no beat lost or duplicated.
- MAX_BEATS=4; lane 5 sends 6 beats with tlast on beat 6. Expect:
  - tlast on output beat 4 and err_overlen=1;
  - beats 5–6 emitted as a second packet after re-arbitration.
- Lane 2: I_tlast=1 and Q_tlast=0 on beat 2. Expect:
  - output tlast=1 and err_tlast_mismatch=1;
  - err_clr clears it;
  - a simultaneous new mismatch keeps it at 1.
- Reset pulse mid-packet on lane 6, and lane_en=0x40 deasserted mid-packet in a separate run. Expect:
  - on reset: all outputs 0 immediately and rr_ptr=0; after release, lane 0 has priority;
  - lane_en deassert mid-packet: the packet still completes.
